// File: rtl/pipe_hazard_ctrl.sv
// Per-stage valid/allowin/advance/stall controller with inst-bus and data-bus handshakes.
// Optional PIPE_PERF_EN adds a 32-bit stall counter per stage on perf_stall_cnt.
module pipe_hazard_ctrl #(
    parameter int NSTAGE  = 5,
    parameter int MEM_IDX = 3,
    parameter int DISC_W  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NSTAGE-1:0]    stage_ready_go,
    input  logic [NSTAGE-1:0]    stage_flush,
    output logic                 inst_req,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    output logic                 inst_resp_vld,
    input  logic                 mem_ls,
    output logic                 data_req,
    input  logic                 data_addr_ok,
    input  logic                 data_data_ok,
    output logic [NSTAGE-1:0]    stage_valid,
    output logic [NSTAGE-1:0]    stage_allowin,
    output logic [NSTAGE-1:0]    stage_advance,
    output logic [NSTAGE-1:0]    stage_stall
`ifdef PIPE_PERF_EN
    ,
    output logic [32*NSTAGE-1:0] perf_stall_cnt
`endif
);

    localparam logic [DISC_W-1:0] DISC_MAX = '1;

    logic [NSTAGE-1:0] valid_q, valid_d;
    logic              inst_got_q, inst_got_d;
    logic              data_sent_q, data_sent_d;
    logic              data_got_q, data_got_d;
    logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;

    logic [NSTAGE-1:0] rg;
    logic              deliver;
    logic              disc_full;
    logic              inst_hs;
    logic              data_hs;
    logic              data_ok_acc;
    logic              disc_inc;
    logic              disc_dec;

    // The allowin chain is resolved from WB backwards; WB always accepts.
    always_comb begin : comb_handshake
        logic chain;
        disc_full     = (disc_cnt_q == DISC_MAX);
        deliver       = inst_data_ok & (disc_cnt_q == '0) & valid_q[0] & ~inst_got_q;
        data_req      = valid_q[MEM_IDX] & mem_ls & ~data_sent_q;
        data_hs       = data_req & data_addr_ok;
        data_ok_acc   = data_data_ok & (data_sent_q | data_hs);
        rg            = '0;
        stage_allowin = '0;
        stage_advance = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i == 0) begin
                rg[i] = stage_ready_go[i] & (inst_got_q | deliver);
            end else if (i == MEM_IDX) begin
                rg[i] = stage_ready_go[i] & (~mem_ls | data_got_q | data_ok_acc);
            end else begin
                rg[i] = stage_ready_go[i];
            end
        end
        chain = 1'b1;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            stage_advance[i] = valid_q[i] & rg[i] & chain;
            if (i == NSTAGE - 1) begin
                stage_allowin[i] = 1'b1;
            end else begin
                stage_allowin[i] = ~valid_q[i] | (rg[i] & chain);
            end
            chain = stage_allowin[i];
        end
        stage_valid   = valid_q;
        stage_stall   = valid_q & ~stage_advance;
        inst_req      = resetn & stage_allowin[0] & ~(valid_q[0] & ~stage_advance[0]) & ~disc_full;
        inst_hs       = inst_req & inst_addr_ok;
        inst_resp_vld = deliver;
    end

    always_comb begin : comb_next
        valid_d = valid_q;
        for (int i = 1; i < NSTAGE; i++) begin
            if ((i < MEM_IDX) && stage_flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (stage_allowin[i]) begin
                valid_d[i] = stage_advance[i-1];
            end
        end
        if (inst_hs) begin
            valid_d[0] = 1'b1;
        end else if (stage_flush[0] | stage_advance[0]) begin
            valid_d[0] = 1'b0;
        end

        inst_got_d = inst_got_q;
        if (inst_hs | stage_advance[0] | stage_flush[0]) begin
            inst_got_d = 1'b0;
        end else if (deliver) begin
            inst_got_d = 1'b1;
        end

        // A flushed fetch whose response is not arriving now leaves an orphan to drop later.
        disc_dec   = inst_data_ok & (disc_cnt_q != '0);
        disc_inc   = stage_flush[0] & valid_q[0] & ~inst_got_q & ~deliver;
        disc_cnt_d = disc_cnt_q;
        if (disc_inc & ~disc_dec) begin
            disc_cnt_d = disc_cnt_q + DISC_W'(1);
        end else if (disc_dec & ~disc_inc) begin
            disc_cnt_d = disc_cnt_q - DISC_W'(1);
        end

        data_sent_d = data_sent_q;
        data_got_d  = data_got_q;
        if (stage_advance[MEM_IDX]) begin
            data_sent_d = 1'b0;
            data_got_d  = 1'b0;
        end else begin
            if (data_hs) begin
                data_sent_d = 1'b1;
            end
            if (data_ok_acc) begin
                data_got_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q     <= '0;
            inst_got_q  <= 1'b0;
            data_sent_q <= 1'b0;
            data_got_q  <= 1'b0;
            disc_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            inst_got_q  <= inst_got_d;
            data_sent_q <= data_sent_d;
            data_got_q  <= data_got_d;
            disc_cnt_q  <= disc_cnt_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [32*NSTAGE-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int i = 0; i < NSTAGE; i++) begin
            perf_d[32*i +: 32] = perf_q[32*i +: 32] + {31'd0, stage_stall[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner cases, random vs model.
module tb_pipe_hazard_ctrl;

    localparam int NSTAGE   = 5;
    localparam int MEM_IDX  = 3;
    localparam int DISC_MAX = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NSTAGE-1:0] stage_ready_go;
    logic [NSTAGE-1:0] stage_flush;
    logic              inst_req;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic              inst_resp_vld;
    logic              mem_ls;
    logic              data_req;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [NSTAGE-1:0] stage_valid;
    logic [NSTAGE-1:0] stage_allowin;
    logic [NSTAGE-1:0] stage_advance;
    logic [NSTAGE-1:0] stage_stall;
`ifdef PIPE_PERF_EN
    logic [32*NSTAGE-1:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .MEM_IDX(MEM_IDX), .DISC_W(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .stage_ready_go (stage_ready_go),
        .stage_flush    (stage_flush),
        .inst_req       (inst_req),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_resp_vld  (inst_resp_vld),
        .mem_ls         (mem_ls),
        .data_req       (data_req),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .stage_valid    (stage_valid),
        .stage_allowin  (stage_allowin),
        .stage_advance  (stage_advance),
        .stage_stall    (stage_stall)
`ifdef PIPE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [NSTAGE-1:0] rg;
        logic [NSTAGE-1:0] exp_valid;
        logic [NSTAGE-1:0] exp_stall;
        logic              exp_req;
        logic              exp_resp;
        logic              exp_dreq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NSTAGE-1:0] rg, input logic [NSTAGE-1:0] fl,
                         input logic iaok, input logic idok, input logic ls,
                         input logic daok, input logic ddok);
        @(negedge clk);
        stage_ready_go = rg;
        stage_flush    = fl;
        inst_addr_ok   = iaok;
        inst_data_ok   = idok;
        mem_ls         = ls;
        data_addr_ok   = daok;
        data_data_ok   = ddok;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn         = 1'b0;
        stage_ready_go = '1;
        stage_flush    = '0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        mem_ls         = 1'b0;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        #1;
        check("rst_valid", 32'(stage_valid), 32'd0);
        check("rst_inst_req", 32'(inst_req), 32'd0);
        check("rst_data_req", 32'(data_req), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic add_vec(input logic [NSTAGE-1:0] rg, input logic [NSTAGE-1:0] v,
                           input logic [NSTAGE-1:0] s, input logic rq, input logic rs,
                           input logic dq);
        vec_t t;
        t.rg = rg; t.exp_valid = v; t.exp_stall = s;
        t.exp_req = rq; t.exp_resp = rs; t.exp_dreq = dq;
        vecs.push_back(t);
    endtask

    // Reference model state: live stage bits, pending fetch queue (1 = orphaned), MEM bus phase.
    bit             mv[NSTAGE];
    bit             m_got;
    bit             m_sent;
    bit             m_dgot;
    bit             fetchq[$];

    task automatic run_random(input int ncycles);
        for (int c = 0; c < ncycles && failures < 40; c++) begin
            logic [NSTAGE-1:0] rgi, fl, ev, ea, ead, es;
            logic iaok, idok, ls, daok, ddok;
            bit rgm[NSTAGE];
            bit ain[NSTAGE];
            bit adv[NSTAGE];
            bit nv[NSTAGE];
            int orphans;
            bit dlv, dreq, dacc, req, hs;

            for (int i = 0; i < NSTAGE; i++) begin
                rgi[i] = ($urandom_range(0, 99) < 85);
                fl[i]  = ($urandom_range(0, 99) < 6);
            end
            iaok = $urandom_range(0, 1);
            idok = (fetchq.size() > 0) && ($urandom_range(0, 1) == 1);
            ls   = $urandom_range(0, 1);
            daok = $urandom_range(0, 1);
            ddok = ($urandom_range(0, 9) < 4);
            drive(rgi, fl, iaok, idok, ls, daok, ddok);

            orphans = 0;
            foreach (fetchq[k]) orphans += fetchq[k];
            dlv  = idok && fetchq.size() > 0 && fetchq[0] == 0 && mv[0] && !m_got;
            dreq = mv[MEM_IDX] && ls && !m_sent;
            dacc = ddok && (m_sent || (dreq && daok));
            for (int i = 0; i < NSTAGE; i++) begin
                if (i == 0)            rgm[i] = rgi[i] && (m_got || dlv);
                else if (i == MEM_IDX) rgm[i] = rgi[i] && (!ls || m_dgot || dacc);
                else                   rgm[i] = rgi[i];
            end
            ain[NSTAGE-1] = 1;
            adv[NSTAGE-1] = mv[NSTAGE-1] && rgm[NSTAGE-1];
            for (int i = NSTAGE - 2; i >= 0; i--) begin
                adv[i] = mv[i] && rgm[i] && ain[i+1];
                ain[i] = !mv[i] || adv[i];
            end
            req = (!mv[0] || adv[0]) && (orphans < DISC_MAX);
            for (int i = 0; i < NSTAGE; i++) begin
                ev[i] = mv[i]; ea[i] = ain[i]; ead[i] = adv[i]; es[i] = mv[i] && !adv[i];
            end
            check("rnd_valid", 32'(stage_valid), 32'(ev));
            check("rnd_allowin", 32'(stage_allowin), 32'(ea));
            check("rnd_advance", 32'(stage_advance), 32'(ead));
            check("rnd_stall", 32'(stage_stall), 32'(es));
            check("rnd_inst_req", 32'(inst_req), 32'(req));
            check("rnd_resp_vld", 32'(inst_resp_vld), 32'(dlv));
            check("rnd_data_req", 32'(data_req), 32'(dreq));

            hs = req && iaok;
            for (int i = NSTAGE - 1; i >= 1; i--) begin
                if (i < MEM_IDX && fl[i]) nv[i] = 0;
                else if (ain[i])          nv[i] = adv[i-1];
                else                      nv[i] = mv[i];
            end
            if (idok && fetchq.size() > 0) void'(fetchq.pop_front());
            if (fl[0] && mv[0] && !m_got && !dlv && fetchq.size() > 0) fetchq[fetchq.size()-1] = 1;
            if (hs) fetchq.push_back(0);
            if (hs) begin
                nv[0] = 1; m_got = 0;
            end else if (fl[0] || adv[0]) begin
                nv[0] = 0; m_got = 0;
            end else begin
                nv[0] = mv[0];
                if (dlv) m_got = 1;
            end
            if (adv[MEM_IDX]) begin
                m_sent = 0; m_dgot = 0;
            end else begin
                if (dreq && daok) m_sent = 1;
                if (dacc) m_dgot = 1;
            end
            mv = nv;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Free flow, then ready_go[2] held low for three cycles.
        for (int r = 0; r < 8; r++) begin
            logic [NSTAGE-1:0] v;
            v = (r >= NSTAGE) ? '1 : NSTAGE'((1 << r) - 1);
            add_vec('1, v, '0, 1'b1, (r > 0), (r >= 4));
        end
        add_vec(5'b11011, 5'b11111, 5'b00111, 1'b0, 1'b1, 1'b1);
        add_vec(5'b11011, 5'b10111, 5'b00111, 1'b0, 1'b0, 1'b0);
        add_vec(5'b11011, 5'b00111, 5'b00111, 1'b0, 1'b0, 1'b0);
        add_vec(5'b11111, 5'b00111, 5'b00000, 1'b1, 1'b0, 1'b0);
        add_vec(5'b11111, 5'b01111, 5'b00000, 1'b1, 1'b1, 1'b1);

        do_reset();
        foreach (vecs[r]) begin
            drive(vecs[r].rg, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            check($sformatf("vec%0d_valid", r), 32'(stage_valid), 32'(vecs[r].exp_valid));
            check($sformatf("vec%0d_stall", r), 32'(stage_stall), 32'(vecs[r].exp_stall));
            check($sformatf("vec%0d_inst_req", r), 32'(inst_req), 32'(vecs[r].exp_req));
            check($sformatf("vec%0d_resp_vld", r), 32'(inst_resp_vld), 32'(vecs[r].exp_resp));
            check($sformatf("vec%0d_data_req", r), 32'(data_req), 32'(vecs[r].exp_dreq));
        end
`ifdef PIPE_PERF_EN
        check("perf_slice2", perf_stall_cnt[64 +: 32], 32'd3);
`endif

        // Orphan drop: flushed fetch's late response must not reach IF.
        do_reset();
        drive('1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("orph_req0", 32'(inst_req), 32'd1);
        drive('1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("orph_req_flush", 32'(inst_req), 32'd0);
        drive('1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("orph_req_refetch", 32'(inst_req), 32'd1);
        drive('1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("orph_drop_resp", 32'(inst_resp_vld), 32'd0);
        check("orph_drop_adv", 32'(stage_advance[0]), 32'd0);
        drive('1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("orph_next_resp", 32'(inst_resp_vld), 32'd1);
        check("orph_next_adv", 32'(stage_advance[0]), 32'd1);

        // Discard saturation: three orphans block further fetches until one drains.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive('1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("sat_req_issue%0d", k), 32'(inst_req), 32'd1);
            drive('1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive('1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_req_full", 32'(inst_req), 32'd0);
        drive('1, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_req_drain", 32'(inst_req), 32'd0);
        check("sat_resp_drain", 32'(inst_resp_vld), 32'd0);
        drive('1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_req_after", 32'(inst_req), 32'd1);

        // Load in MEM: addr_ok at t, data_ok at t+4, flush of MEM ignored.
        do_reset();
        drive('1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive('1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive('1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive('1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive('1, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ld_valid_t", 32'(stage_valid), 32'b01000);
        check("ld_dreq_t", 32'(data_req), 32'd1);
        check("ld_stall_t", 32'(stage_stall[MEM_IDX]), 32'd1);
        for (int k = 1; k < 4; k++) begin
            drive('1, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("ld_stall_t%0d", k), 32'(stage_stall[MEM_IDX]), 32'd1);
            check($sformatf("ld_dreq_t%0d", k), 32'(data_req), 32'd0);
            check($sformatf("ld_valid_t%0d", k), 32'(stage_valid), 32'b01000);
        end
        drive('1, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ld_adv_t4", 32'(stage_advance[MEM_IDX]), 32'd1);
        check("ld_stall_t4", 32'(stage_stall[MEM_IDX]), 32'd0);
        drive('1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ld_valid_wb", 32'(stage_valid), 32'b10000);

        // Randomised traffic against the queue-based model.
        do_reset();
        mv = '{default: 0};
        m_got = 0; m_sent = 0; m_dgot = 0;
        fetchq.delete();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
